// File: rtl/fetch_queue.sv
// Instruction-fetch front end: issues word reads, byte-swaps the returned words and
// queues them with their PCs for decode, under redirect and flush control.
module fetch_queue #(
  parameter int unsigned PC_WIDTH     = 20,
  parameter int unsigned WORD_WIDTH   = 16,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned OFFSET_WIDTH = 9,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                    clock,
  input  logic                    reset,
  output logic [PC_WIDTH-1:0]     imem_addr,
  output logic                    imem_req,
  input  logic [WORD_WIDTH-1:0]   imem_rdata,
  input  logic                    redirect_valid,
  input  logic                    redirect_mode,
  input  logic [PC_WIDTH-1:0]     redirect_base,
  input  logic [OFFSET_WIDTH-1:0] redirect_offset,
  input  logic [PC_WIDTH-1:0]     redirect_target,
  input  logic                    flush,
  output logic                    out_valid,
  output logic                    out_ext_valid,
  output logic [2*WORD_WIDTH-1:0] out_instr,
  output logic [PC_WIDTH-1:0]     out_pc,
  input  logic [1:0]              out_pop
);

  localparam int unsigned PtrW     = $clog2(DEPTH);
  localparam int unsigned CntW     = PtrW + 1;
  localparam int              NumBytes = WORD_WIDTH / 8;

  logic [PC_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic                  inflight_q, inflight_d;
  logic [PC_WIDTH-1:0]   inflight_pc_q, inflight_pc_d;
  logic                  inflight_epoch_q, inflight_epoch_d;
  logic                  epoch_q, epoch_d;

  logic [WORD_WIDTH-1:0] data_q [DEPTH];
  logic [PC_WIDTH-1:0]   pc_q   [DEPTH];

  logic                  credit;
  logic                  issue;
  logic                  steer;
  logic                  push;
  logic                  wr_en;
  logic [WORD_WIDTH-1:0] swapped;
  logic [CntW-1:0]       pop_req;
  logic [CntW-1:0]       pop_eff;
  logic [PC_WIDTH-1:0]   rel_target;
  logic [PC_WIDTH-1:0]   steer_target;
  logic [PtrW-1:0]       rd_ptr_next;

  // Issue credit counts the in-flight word so a response always finds a free slot.
  always_comb begin
    credit    = (int'(count_q) + int'(inflight_q)) < int'(DEPTH);
    steer     = redirect_valid || flush;
    issue     = credit && !steer && !reset;
    imem_req  = issue;
    imem_addr = fetch_pc_q;
  end

  always_comb begin
    swapped = '0;
    for (int k = 0; k < NumBytes; k++) begin
      swapped[8*(NumBytes-1-k) +: 8] = imem_rdata[8*k +: 8];
    end
  end

  // Relative targets subtract one to match the existing AAP branch encoding.
  always_comb begin
    rel_target = redirect_base
               + {{(PC_WIDTH-OFFSET_WIDTH){redirect_offset[OFFSET_WIDTH-1]}}, redirect_offset}
               - PC_WIDTH'(1);
    if (redirect_valid) begin
      steer_target = redirect_mode ? redirect_target : rel_target;
    end else if (count_q != '0) begin
      steer_target = pc_q[rd_ptr_q];
    end else if (inflight_q) begin
      steer_target = inflight_pc_q;
    end else begin
      steer_target = fetch_pc_q;
    end
  end

  always_comb begin
    push    = inflight_q && (inflight_epoch_q == epoch_q);
    pop_req = CntW'(out_pop);
    pop_eff = (pop_req > count_q) ? count_q : pop_req;
  end

  always_comb begin
    fetch_pc_d       = fetch_pc_q;
    rd_ptr_d         = rd_ptr_q;
    wr_ptr_d         = wr_ptr_q;
    count_d          = count_q;
    inflight_d       = 1'b0;
    inflight_pc_d    = inflight_pc_q;
    inflight_epoch_d = inflight_epoch_q;
    epoch_d          = epoch_q;
    wr_en            = 1'b0;

    if (steer) begin
      fetch_pc_d = steer_target;
      rd_ptr_d   = wr_ptr_q;
      count_d    = '0;
      epoch_d    = ~epoch_q;
    end else begin
      if (issue) begin
        fetch_pc_d       = fetch_pc_q + PC_WIDTH'(1);
        inflight_d       = 1'b1;
        inflight_pc_d    = fetch_pc_q;
        inflight_epoch_d = epoch_q;
      end
      if (push && !reset) begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      // Truncation to the pointer width is the intended modulo-DEPTH wrap.
      rd_ptr_d = rd_ptr_q + PtrW'(pop_eff);
      count_d  = count_q - pop_eff + CntW'(push);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_q       <= RESET_PC;
      rd_ptr_q         <= '0;
      wr_ptr_q         <= '0;
      count_q          <= '0;
      inflight_q       <= 1'b0;
      inflight_pc_q    <= '0;
      inflight_epoch_q <= 1'b0;
      epoch_q          <= 1'b0;
    end else begin
      fetch_pc_q       <= fetch_pc_d;
      rd_ptr_q         <= rd_ptr_d;
      wr_ptr_q         <= wr_ptr_d;
      count_q          <= count_d;
      inflight_q       <= inflight_d;
      inflight_pc_q    <= inflight_pc_d;
      inflight_epoch_q <= inflight_epoch_d;
      epoch_q          <= epoch_d;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) begin
      data_q[wr_ptr_q] <= swapped;
      pc_q[wr_ptr_q]   <= inflight_pc_q;
    end
  end

  always_comb begin
    rd_ptr_next   = rd_ptr_q + PtrW'(1);
    out_valid     = count_q != '0;
    out_ext_valid = count_q >= CntW'(2);
    out_instr     = '0;
    out_pc        = '0;
    if (out_valid) begin
      out_instr[2*WORD_WIDTH-1:WORD_WIDTH] = data_q[rd_ptr_q];
      out_pc                               = pc_q[rd_ptr_q];
    end
    if (out_ext_valid) begin
      out_instr[WORD_WIDTH-1:0] = data_q[rd_ptr_next];
    end
  end

  pop_in_range: assert property (@(posedge clock) disable iff (reset || redirect_valid || flush)
                                 (CntW'(out_pop) <= count_q));

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
Parametrised instruction-fetch front end for the AAP pipeline. It generates instruction-memory addresses, byte-swaps returned words and buffers them with their PCs in a DEPTH-entry queue. Decode consumes one or two words per cycle through a pop handshake. Decode/execute steer it with relative or absolute redirects and flushes.

Parameters:
PC_WIDTH, 20, width of program counter and memory address (word-addressed)
WORD_WIDTH, 16, instruction word width; multiple of 8
DEPTH, 4, queue entries; power of two, >= 2
OFFSET_WIDTH, 9, width of signed relative branch offset
RESET_PC, 0, fetch address after reset

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high
imem_addr  out  PC_WIDTH  instruction memory word address
imem_req  out  1  read request this cycle
imem_rdata  in  WORD_WIDTH  read data, valid exactly one cycle after an accepted imem_req
redirect_valid  in  1  redirect fetch this cycle
redirect_mode  in  1  0 = relative, 1 = absolute
redirect_base  in  PC_WIDTH  PC of the branching instruction (relative mode)
redirect_offset  in  OFFSET_WIDTH  signed two's-complement offset (relative mode)
redirect_target  in  PC_WIDTH  destination (absolute mode)
flush  in  1  discard buffered/in-flight words; refetch from head PC
out_valid  out  1  queue holds >= 1 word
out_ext_valid  out  1  queue holds >= 2 words
out_instr  out  2*WORD_WIDTH  [2W-1:W] = head word, [W-1:0] = next word (0 if absent)
out_pc  out  PC_WIDTH  PC of head word
out_pop  in  2  words consumed this cycle: 0, 1 or 2

Behaviour:
- Reset (clock edge with reset=1): fetch_pc = RESET_PC, queue empty, in-flight flag clear, imem_req=0, out_valid=out_ext_valid=0, out_instr=0, out_pc=0. Reset overrides all inputs, including a pending response.
- Issue: imem_req=1, imem_addr=fetch_pc when count + inflight < DEPTH (count = occupancy at cycle start, inflight 0/1). On issue, fetch_pc increments by 1 modulo 2^PC_WIDTH (wrap from all-ones to 0).
- Response: the cycle after an issue, the word is written to the queue tail with its address unless discarded. Byte order is reversed: byte k of imem_rdata becomes byte (WORD_WIDTH/8-1-k). For the default width, stored = {rdata[7:0], rdata[15:8]}.
- The credit rule guarantees a response always has a free slot. Overflow is impossible by construction; bench asserts it.
- Pop: out_pop removes head words at the clock edge. Push and pop in the same cycle are allowed. Pop > occupancy is illegal: clip to occupancy and assert in simulation. Pop=2 requires out_ext_valid.
- Outputs are driven combinationally from registered queue state. Earliest word after reset/redirect: issue at cycle t, write at t+1 edge, out_valid at t+2.
- Redirect target:
  - absolute: redirect_target.
  - relative: redirect_base + sign_extend(redirect_offset) − 1, modulo 2^PC_WIDTH. The −1 preserves the existing AAP branch encoding.
- Redirect effect: at the edge, the queue is emptied, fetch_pc = target, and any in-flight response is marked stale and dropped on arrival. No issue occurs in the redirect cycle. The first new issue is in the following cycle.
- Flush: same as redirect with target = out_pc. If the queue is empty, target = oldest in-flight PC, else fetch_pc.
- Priority: reset > redirect > flush > pop/push. out_pop in a redirect/flush cycle is ignored.
- Stale tracking: one-bit epoch toggled on redirect/flush. Each response is tagged with the issue epoch and dropped on mismatch.

Test Plan:
1. Reset, memory returns 0x3412 at addr 0, 0x7856 at addr 1; out_pop=1 every cycle -> out_instr[31:16]=0x1234 then 0x5678, out_pc 0 then 1; steady state one word per cycle.
2. out_pop=0 for 10 cycles -> exactly 4 requests (addrs 0..3), then imem_req stays 0, out_ext_valid=1. out_pop=2 once -> addrs 0,1 removed, out_pc=2, issue resumes at addr 4.
3. Relative redirect, base=0x00010, offset=9'h1FD (−3) while a request is in flight -> next imem_addr=0x0000C; stale word never appears; first out_pc=0x0000C.
4. Absolute redirect to 0xFFFFF -> addresses 0xFFFFF then 0x00000; out_pc wraps correctly.
5. redirect_valid and flush in the same cycle, queue holding PCs 5,6 -> redirect target wins, queue emptied, no word with PC 5 re-emerges.
6. Assert reset mid-stream with 3 words queued and 1 in flight -> next cycle all outputs 0, in-flight response ignored, first request is RESET_PC.
